// File: rtl/rv32_instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// Master drives request fields and consumer ready; slave answers.
interface rv32_instr_encoder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ERR_CNT_W  = 8
);
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [2:0]            fmt_i;
   logic [6:0]            opcode_i;
   logic [4:0]            rd_i;
   logic [4:0]            rs1_i;
   logic [4:0]            rs2_i;
   logic [2:0]            funct3_i;
   logic [6:0]            funct7_i;
   logic [DATA_WIDTH-1:0] imm_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] instr_o;
   logic                  err_o;
   logic [ERR_CNT_W-1:0]  err_cnt_o;

   modport master (
      output in_valid_i, fmt_i, opcode_i,
      output rd_i, rs1_i, rs2_i,
      output funct3_i, funct7_i, imm_i,
      output out_ready_i,
      input  in_ready_o, out_valid_o,
      input  instr_o, err_o, err_cnt_o
   );

   modport slave (
      input  in_valid_i, fmt_i, opcode_i,
      input  rd_i, rs1_i, rs2_i,
      input  funct3_i, funct7_i, imm_i,
      input  out_ready_i,
      output in_ready_o, out_valid_o,
      output instr_o, err_o, err_cnt_o
   );
endinterface

// File: rtl/rv32_instr_encoder.sv
// Two-stage RV32I encoder: range check in s1, bit scatter in s2.
// Optional immediate round-trip check: RV32_INSTR_ENCODER_ROUNDTRIP_CHECK_EN.
module rv32_instr_encoder #(
   parameter int DATA_WIDTH = 32,
   parameter int ERR_CNT_W  = 8
) (
   input logic                 clk_i,
   input logic                 rst_i,
   rv32_instr_encoder_if.slave bus
);

   localparam logic [2:0] FMT_I = 3'b000;
   localparam logic [2:0] FMT_S = 3'b001;
   localparam logic [2:0] FMT_B = 3'b010;
   localparam logic [2:0] FMT_J = 3'b011;
   localparam logic [2:0] FMT_U = 3'b100;
   localparam logic [2:0] FMT_R = 3'b101;

   localparam logic [DATA_WIDTH-1:0] NOP =
      DATA_WIDTH'(32'h0000_0013);

   typedef struct packed {
      logic [2:0]            fmt;
      logic [6:0]            op;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [2:0]            f3;
      logic [6:0]            f7;
      logic [DATA_WIDTH-1:0] imm;
      logic                  err;
   } s1_t;

   s1_t                   s1_d;
   s1_t                   s1_q;
   logic                  s1_valid;
   logic                  s2_valid;
   logic                  s1_load;
   logic                  s2_load;
   logic                  imm_bad;
   logic                  rt_bad;
   logic                  err_s2;
   logic [DATA_WIDTH-1:0] pack_w;
   logic [DATA_WIDTH-1:0] instr_d;
   logic [DATA_WIDTH-1:0] instr_q;
   logic                  err_q;
   logic [ERR_CNT_W-1:0]  cnt_q;

   assign s2_load = !s2_valid || bus.out_ready_i;
   assign s1_load = !s1_valid || s2_load;

   // Immediate must fit the field the format can carry.
   always_comb begin
      imm_bad = 1'b1;
      unique case (1'b1)
         (bus.fmt_i == FMT_I) || (bus.fmt_i == FMT_S):
            imm_bad = !(&bus.imm_i[31:11] || ~|bus.imm_i[31:11]);
         bus.fmt_i == FMT_B:
            imm_bad = !(&bus.imm_i[31:12] || ~|bus.imm_i[31:12])
                   || bus.imm_i[0];
         bus.fmt_i == FMT_J:
            imm_bad = !(&bus.imm_i[31:20] || ~|bus.imm_i[31:20])
                   || bus.imm_i[0];
         bus.fmt_i == FMT_U:
            imm_bad = |bus.imm_i[11:0];
         bus.fmt_i == FMT_R:
            imm_bad = 1'b0;
         default:
            imm_bad = 1'b1;
      endcase
   end

   always_comb begin
      s1_d     = '0;
      s1_d.fmt = bus.fmt_i;
      s1_d.op  = bus.opcode_i | 7'b000_0011;
      s1_d.rd  = bus.rd_i;
      s1_d.rs1 = bus.rs1_i;
      s1_d.rs2 = bus.rs2_i;
      s1_d.f3  = bus.funct3_i;
      s1_d.f7  = bus.funct7_i;
      s1_d.imm = bus.imm_i;
      s1_d.err = imm_bad;
   end

   always_comb begin
      pack_w = NOP;
      unique case (1'b1)
         s1_q.fmt == FMT_I:
            pack_w = {s1_q.imm[11:0], s1_q.rs1,
                      s1_q.f3, s1_q.rd, s1_q.op};
         s1_q.fmt == FMT_S:
            pack_w = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1,
                      s1_q.f3, s1_q.imm[4:0], s1_q.op};
         s1_q.fmt == FMT_B:
            pack_w = {s1_q.imm[12], s1_q.imm[10:5],
                      s1_q.rs2, s1_q.rs1, s1_q.f3,
                      s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
         s1_q.fmt == FMT_J:
            pack_w = {s1_q.imm[20], s1_q.imm[10:1],
                      s1_q.imm[11], s1_q.imm[19:12],
                      s1_q.rd, s1_q.op};
         s1_q.fmt == FMT_U:
            pack_w = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
         s1_q.fmt == FMT_R:
            pack_w = {s1_q.f7, s1_q.rs2, s1_q.rs1,
                      s1_q.f3, s1_q.rd, s1_q.op};
         default:
            pack_w = NOP;
      endcase
   end

`ifdef RV32_INSTR_ENCODER_ROUNDTRIP_CHECK_EN
   logic [DATA_WIDTH-1:0] rt_imm;
   logic                  rt_fmt;

   // Re-extract exactly as the immediate generator would.
   always_comb begin
      rt_imm = '0;
      rt_fmt = 1'b1;
      unique case (1'b1)
         s1_q.fmt == FMT_I:
            rt_imm = {{20{pack_w[31]}}, pack_w[31:20]};
         s1_q.fmt == FMT_S:
            rt_imm = {{20{pack_w[31]}}, pack_w[31:25],
                      pack_w[11:7]};
         s1_q.fmt == FMT_B:
            rt_imm = {{19{pack_w[31]}}, pack_w[31], pack_w[7],
                      pack_w[30:25], pack_w[11:8], 1'b0};
         s1_q.fmt == FMT_J:
            rt_imm = {{11{pack_w[31]}}, pack_w[31],
                      pack_w[19:12], pack_w[20],
                      pack_w[30:21], 1'b0};
         s1_q.fmt == FMT_U:
            rt_imm = {pack_w[31:12], 12'b0};
         default:
            rt_fmt = 1'b0;
      endcase
      rt_bad = rt_fmt && !s1_q.err && (rt_imm != s1_q.imm);
   end
`else
   assign rt_bad = 1'b0;
`endif

   assign err_s2  = s1_q.err || rt_bad;
   assign instr_d = err_s2 ? NOP : pack_w;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid_i;
         if (bus.in_valid_i) s1_q <= s1_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid <= 1'b0;
         instr_q  <= '0;
         err_q    <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            instr_q <= instr_d;
            err_q   <= err_s2;
         end
      end
   end

   // Count on the output handshake; hold at all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (s2_valid && bus.out_ready_i && err_q
                   && (cnt_q != '1)) begin
         cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
   end

   assign bus.in_ready_o  = s1_load;
   assign bus.out_valid_o = s2_valid;
   assign bus.instr_o     = instr_q;
   assign bus.err_o       = err_q;
   assign bus.err_cnt_o   = cnt_q;

endmodule
